alu4_cmd_unit: RTL and testbench

Command-issuing front end for the `alu4` combinational datapath. It accepts ALU commands over a valid/ready handshake and reads operands from a small internal register file. It drives `alu4`'s `A`/`B`/`opcode` inputs, captures `Result`/`carry`/`zero`, writes the result back, and returns a response over a second valid/ready handshake. It sits between a command source (sequencer or host) and one `alu4` instance, turning the stateless ALU into a usable register-to-register execution unit.

---
 rtl/alu4_cmd_if.sv | 40 ++++
 rtl/alu4_cmd_unit.sv | 128 ++++++++++++
 tb/tb_alu4_cmd_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu4_cmd_if.sv
// Command and response handshake bundle for alu4_cmd_unit.
interface alu4_cmd_if #(
  parameter int unsigned NREG = 4
) ();
  localparam int unsigned RAW = $clog2(NREG);

  // Command channel
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [RAW-1:0] cmd_rd;
  logic [RAW-1:0] cmd_ra;
  logic [RAW-1:0] cmd_rb;
  logic           cmd_imm_en;
  logic [3:0]     cmd_imm;

  // Response channel
  logic           rsp_valid;
  logic           rsp_ready;
  logic [3:0]     rsp_data;
  logic           rsp_carry;
  logic           rsp_zero;
  logic [RAW-1:0] rsp_rd;

  // Command source / response consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_rd,
    output rsp_ready
  );

  // Execution unit side
  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_rd,
    input  rsp_ready
  );
endinterface

// File: rtl/alu4_cmd_unit.sv
// Register-to-register execution front end around an external alu4:
// accepts a command, drives the ALU for one cycle, writes back, responds.
module alu4_cmd_unit #(
  parameter int unsigned NREG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu4_cmd_if.slave                cmd_if,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_op,
  input  logic [3:0]               alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic [$clog2(NREG)-1:0]  dbg_sel,
  output logic [3:0]               dbg_data
);
  localparam int unsigned RAW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e         state_q, state_d;
  logic [3:0]     regs_q [NREG];
  logic [3:0]     regs_d [NREG];
  logic [3:0]     alu_a_q, alu_a_d;
  logic [3:0]     alu_b_q, alu_b_d;
  logic [2:0]     alu_op_q, alu_op_d;
  logic [RAW-1:0] rd_q, rd_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [3:0]     rsp_data_q, rsp_data_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic [RAW-1:0] rsp_rd_q, rsp_rd_d;

  // State, register file, ALU operand and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= 4'd0;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      alu_op_q    <= 3'd0;
      rd_q        <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'd0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_rd_d    = rsp_rd_q;

    case (state_q)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          // Operands sampled now, so rd==ra/rb sees the old value
          alu_a_d     = regs_q[cmd_if.cmd_ra];
          alu_b_d     = cmd_if.cmd_imm_en ? cmd_if.cmd_imm : regs_q[cmd_if.cmd_rb];
          alu_op_d    = cmd_if.cmd_op;
          rd_d        = cmd_if.cmd_rd;
          cmd_ready_d = 1'b0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        regs_d[rd_q] = alu_result;
        rsp_data_d   = alu_result;
        rsp_carry_d  = alu_carry;
        rsp_zero_d   = alu_zero;
        rsp_rd_d     = rd_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (cmd_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  assign cmd_if.cmd_ready = cmd_ready_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;
  assign cmd_if.rsp_carry = rsp_carry_q;
  assign cmd_if.rsp_zero  = rsp_zero_q;
  assign cmd_if.rsp_rd    = rsp_rd_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_op           = alu_op_q;
  assign dbg_data         = regs_q[dbg_sel];
endmodule

// File: tb/tb_alu4_cmd_unit.sv
// Directed, table-driven bench for alu4_cmd_unit with a behavioural alu4.
module tb_alu4_cmd_unit;
  logic       clk;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_carry, alu_zero;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;
  logic [4:0] alu_t;

  int n_checks = 0;
  int n_errors = 0;

  alu4_cmd_if #(.NREG(4)) cmd_if ();

  alu4_cmd_unit #(.NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_if     (cmd_if),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu4: carry is bit 4 of the 5-bit result (borrow for SUB/DEC)
  always_comb begin
    alu_t = 5'd0;
    case (alu_op)
      3'b000: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: alu_t = {1'b0, alu_a & alu_b};
      3'b011: alu_t = {1'b0, alu_a | alu_b};
      3'b100: alu_t = {1'b0, alu_a ^ alu_b};
      3'b101: alu_t = {1'b0, ~alu_a};
      3'b110: alu_t = {1'b0, alu_a} + 5'd1;
      default: alu_t = {1'b0, alu_a} - 5'd1;
    endcase
    alu_result = alu_t[3:0];
    alu_carry  = alu_t[4];
    alu_zero   = (alu_t[3:0] == 4'd0);
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       imm_en;
    logic [3:0] imm;
    logic [3:0] e_data;
    logic       e_c;
    logic       e_z;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb,
                           input logic imm_en, input logic [3:0] imm);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = op;
    cmd_if.cmd_rd     = rd;
    cmd_if.cmd_ra     = ra;
    cmd_if.cmd_rb     = rb;
    cmd_if.cmd_imm_en = imm_en;
    cmd_if.cmd_imm    = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs_zero(input string nm);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      chk(nm, int'(dbg_data), 0);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_rsp_valid"}, int'(cmd_if.rsp_valid), 0);
    chk({nm, "_rsp_data"},  int'(cmd_if.rsp_data), 0);
    chk({nm, "_rsp_carry"}, int'(cmd_if.rsp_carry), 0);
    chk({nm, "_rsp_zero"},  int'(cmd_if.rsp_zero), 0);
    chk({nm, "_rsp_rd"},    int'(cmd_if.rsp_rd), 0);
    chk({nm, "_alu_a"},     int'(alu_a), 0);
    chk({nm, "_alu_b"},     int'(alu_b), 0);
    chk({nm, "_alu_op"},    int'(alu_op), 0);
    chk_regs_zero({nm, "_regs"});
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'b0101, 4'b0101, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'b0011, 4'b1000, 1'b0, 1'b0};
    vecs[2]  = '{3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0};
    vecs[3]  = '{3'b000, 2'd3, 2'd1, 2'd0, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1};
    vecs[4]  = '{3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'b1100, 4'b1100, 1'b0, 1'b0};
    vecs[5]  = '{3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 4'b1010, 4'b1010, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 2'd3, 2'd1, 2'd2, 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 2'd3, 2'd1, 2'd2, 1'b0, 4'b0000, 4'b1110, 1'b0, 1'b0};
    vecs[8]  = '{3'b101, 2'd3, 2'd1, 2'd2, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b0};
    vecs[9]  = '{3'b100, 2'd1, 2'd1, 2'd2, 1'b0, 4'b0000, 4'b0110, 1'b0, 1'b0};
    vecs[10] = '{3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 4'b0000, 4'b1100, 1'b1, 1'b0};
    vecs[11] = '{3'b001, 2'd0, 2'd2, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[12] = '{3'b110, 2'd2, 2'd1, 2'd0, 1'b0, 4'b0000, 4'b0111, 1'b0, 1'b0};
    vecs[13] = '{3'b111, 2'd3, 2'd0, 2'd1, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0};

    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b1;   // ignored while in reset
    cmd_if.cmd_op = 3'b110; cmd_if.cmd_rd = 2'd1; cmd_if.cmd_ra = 2'd0;
    cmd_if.cmd_rb = 2'd0; cmd_if.cmd_imm_en = 1'b0; cmd_if.cmd_imm = 4'd0;
    cmd_if.rsp_ready = 1'b1;
    dbg_sel = 2'd0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reset_cmd_ready", int'(cmd_if.cmd_ready), 1);
    chk("reset_rsp_valid_after", int'(cmd_if.rsp_valid), 0);

    // Table: one command every three cycles with rsp_ready tied high
    for (int i = 0; i < NV; i++) begin
      drive_cmd(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].imm_en, vecs[i].imm);
      chk($sformatf("v%0d_cmd_ready", i), int'(cmd_if.cmd_ready), 1);
      tick();  // accept edge
      cmd_if.cmd_valid = 1'b0;
      chk($sformatf("v%0d_exec_ready", i), int'(cmd_if.cmd_ready), 0);
      chk($sformatf("v%0d_exec_valid", i), int'(cmd_if.rsp_valid), 0);
      tick();  // writeback edge
      chk($sformatf("v%0d_rsp_valid", i), int'(cmd_if.rsp_valid), 1);
      chk($sformatf("v%0d_rsp_data", i),  int'(cmd_if.rsp_data), int'(vecs[i].e_data));
      chk($sformatf("v%0d_rsp_carry", i), int'(cmd_if.rsp_carry), int'(vecs[i].e_c));
      chk($sformatf("v%0d_rsp_zero", i),  int'(cmd_if.rsp_zero), int'(vecs[i].e_z));
      chk($sformatf("v%0d_rsp_rd", i),    int'(cmd_if.rsp_rd), int'(vecs[i].rd));
      dbg_sel = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_dbg", i), int'(dbg_data), int'(vecs[i].e_data));
      tick();  // handshake edge
      chk($sformatf("v%0d_idle_valid", i), int'(cmd_if.rsp_valid), 0);
      chk($sformatf("v%0d_idle_ready", i), int'(cmd_if.cmd_ready), 1);
    end
    // Registers now: r0=0 r1=0110 r2=0111 r3=1111

    // Backpressure: INC r3 (1111) -> 0000, consumer stalls 5 cycles
    cmd_if.rsp_ready = 1'b0;
    drive_cmd(3'b110, 2'd1, 2'd3, 2'd0, 1'b0, 4'd0);
    tick();
    drive_cmd(3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 4'b1001);  // waiting command
    tick();
    chk("bp_first_valid", int'(cmd_if.rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp%0d_valid", c), int'(cmd_if.rsp_valid), 1);
      chk($sformatf("bp%0d_data", c),  int'(cmd_if.rsp_data), 0);
      chk($sformatf("bp%0d_carry", c), int'(cmd_if.rsp_carry), 1);
      chk($sformatf("bp%0d_zero", c),  int'(cmd_if.rsp_zero), 1);
      chk($sformatf("bp%0d_rd", c),    int'(cmd_if.rsp_rd), 1);
      chk($sformatf("bp%0d_cmd_ready", c), int'(cmd_if.cmd_ready), 0);
      chk($sformatf("bp%0d_alu_a", c), int'(alu_a), 15);
    end
    cmd_if.rsp_ready = 1'b1;
    tick();  // handshake edge
    chk("bp_release_valid", int'(cmd_if.rsp_valid), 0);
    chk("bp_release_ready", int'(cmd_if.cmd_ready), 1);
    tick();  // waiting command accepted here
    cmd_if.cmd_valid = 1'b0;
    chk("bp_accept_ready", int'(cmd_if.cmd_ready), 0);
    chk("bp_accept_alu_b", int'(alu_b), 9);
    tick();
    chk("bp_next_valid", int'(cmd_if.rsp_valid), 1);
    chk("bp_next_data", int'(cmd_if.rsp_data), 9);
    chk("bp_next_rd", int'(cmd_if.rsp_rd), 2);
    tick();
    chk("bp_next_done", int'(cmd_if.rsp_valid), 0);

    // Reset mid-EXEC: DEC rd=2 on r0
    drive_cmd(3'b111, 2'd2, 2'd0, 2'd0, 1'b0, 4'd0);
    tick();  // accepted, now in EXEC
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("midrst%0d_valid", c), int'(cmd_if.rsp_valid), 0);
    end
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("postrst%0d_valid", c), int'(cmd_if.rsp_valid), 0);
      chk($sformatf("postrst%0d_ready", c), int'(cmd_if.cmd_ready), 1);
    end
    dbg_sel = 2'd2;
    #1;
    chk("postrst_r2", int'(dbg_data), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
